// File: rtl/mem_responder_bram.sv
// mem_responder_bram: block-RAM backed responder for the cache-to-SRAM request
// interface. Services at most one data access and one instruction fetch per
// request sequence, data first, after a programmable number of wait cycles.
//
// Optional build macro: MEM_RESPONDER_RANGE_CHECK_EN
//   When defined, adds output range_err. Addresses with any bit set above the
//   word index read as zero, their writes are dropped, and range_err is high
//   during the corresponding access cycle. When undefined, upper address bits
//   are ignored and accesses wrap modulo the depth.
//
// State table
//   state  | meaning
//   S_IDLE | waiting for a request; latches request fields when one appears
//   S_WAIT | inserting LATENCY wait cycles
//   S_DACC | data read or write to the block RAM
//   S_IACC | instruction fetch from the block RAM
//   S_DONE | one-cycle ready pulse (nrdy low), outputs stable
module mem_responder_bram #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ie,
    input  logic        de,
    input  logic [1:0]  drw,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [31:0] din,
    output logic [31:0] iout,
    output logic [31:0] dout,
    output logic        nrdy
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Wait counter reload value; unused when LATENCY is 0 since WAIT is skipped.
    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DACC = 3'd2,
        S_IACC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  w_de_op;
    logic                  w_req;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] r_iword;
    logic [ADDR_WIDTH-1:0] r_dword;
    logic [31:0]           r_din;
    logic                  r_dwr;
    logic                  r_ireq;
    logic                  r_dreq;
    logic [3:0]            r_cnt;
    logic [31:0]           r_iout;
    logic [31:0]           r_dout;
    logic [31:0]           r_mem [DEPTH];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic r_irange;
    logic r_drange;
`endif

    // Byte-offset bits are never used; upper bits only feed the range check.
    logic w_unused;
    assign w_unused = ^{iaddr[31:ADDR_WIDTH+2], iaddr[1:0],
                        daddr[31:ADDR_WIDTH+2], daddr[1:0]};

    // drw encodings other than read/write do not count as a data request.
    assign w_de_op = de & ((drw == 2'b10) | (drw == 2'b01));
    assign w_req   = ie | w_de_op;

    assign iout = r_iout;
    assign dout = r_dout;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (LATENCY > 0) begin
                        w_next = S_WAIT;
                    end else if (w_de_op) begin
                        w_next = S_DACC;
                    end else begin
                        w_next = S_IACC;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = r_dreq ? S_DACC : S_IACC;
                end
            end
            S_DACC:  w_next = r_ireq ? S_IACC : S_DONE;
            S_IACC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: not-ready flag, RAM write enable and optional range error.
    always_comb begin
        nrdy     = 1'b0;
        w_mem_we = 1'b0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        range_err = 1'b0;
`endif
        case (r_state)
            S_IDLE: nrdy = w_req;
            S_WAIT: nrdy = 1'b1;
            S_DACC: begin
                nrdy = 1'b1;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                w_mem_we  = r_dwr & ~r_drange & ~rst;
                range_err = r_drange;
`else
                w_mem_we  = r_dwr & ~rst;
`endif
            end
            S_IACC: begin
                nrdy = 1'b1;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                range_err = r_irange;
`endif
            end
            default: nrdy = 1'b0;
        endcase
    end

    // Request capture, wait counter and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_iout  <= 32'd0;
            r_dout  <= 32'd0;
            r_iword <= '0;
            r_dword <= '0;
            r_din   <= 32'd0;
            r_dwr   <= 1'b0;
            r_ireq  <= 1'b0;
            r_dreq  <= 1'b0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
            r_irange <= 1'b0;
            r_drange <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_iword <= iaddr[ADDR_WIDTH+1:2];
                        r_dword <= daddr[ADDR_WIDTH+1:2];
                        r_din   <= din;
                        r_dwr   <= (drw == 2'b01);
                        r_ireq  <= ie;
                        r_dreq  <= w_de_op;
                        r_cnt   <= LAT_LOAD;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                        r_irange <= |iaddr[31:ADDR_WIDTH+2];
                        r_drange <= |daddr[31:ADDR_WIDTH+2];
`endif
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DACC: begin
                    if (!r_dwr) begin
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                        r_dout <= r_drange ? 32'd0 : r_mem[r_dword];
`else
                        r_dout <= r_mem[r_dword];
`endif
                    end
                end
                S_IACC: begin
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                    r_iout <= r_irange ? 32'd0 : r_mem[r_iword];
`else
                    r_iout <= r_mem[r_iword];
`endif
                end
                default: ;
            endcase
        end
    end

    // Block RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_dword] <= r_din;
        end
    end

endmodule

// File: tb/tb_mem_responder_bram.sv
// Bench for mem_responder_bram: a LATENCY=2 instance carries most traffic, a
// LATENCY=0 instance covers the zero-wait path. Expected completion cycle and
// read data are queued when a request is driven and compared when ready is seen.
module tb_mem_responder_bram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ie, de, sel;
    logic [1:0]  drw;
    logic [31:0] iaddr, daddr, din;

    logic        ie2, de2, ie0, de0;
    logic [31:0] iout2, dout2, iout0, dout0;
    logic        nrdy2, nrdy0;
    logic [31:0] iout_m, dout_m;
    logic        nrdy_m, rerr_m;

    assign ie2 = ie & ~sel;
    assign de2 = de & ~sel;
    assign ie0 = ie & sel;
    assign de0 = de & sel;

    assign iout_m = sel ? iout0 : iout2;
    assign dout_m = sel ? dout0 : dout2;
    assign nrdy_m = sel ? nrdy0 : nrdy2;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic rerr2, rerr0;
    assign rerr_m = sel ? rerr0 : rerr2;
`else
    assign rerr_m = 1'b0;
`endif

    mem_responder_bram #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .ie(ie2), .de(de2), .drw(drw),
        .iaddr(iaddr), .daddr(daddr), .din(din),
        .iout(iout2), .dout(dout2), .nrdy(nrdy2)
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        , .range_err(rerr2)
`endif
    );

    mem_responder_bram #(.ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .ie(ie0), .de(de0), .drw(drw),
        .iaddr(iaddr), .daddr(daddr), .din(din),
        .iout(iout0), .dout(dout0), .nrdy(nrdy0)
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        , .range_err(rerr0)
`endif
    );

    typedef struct {
        logic        ie;
        logic        de;
        logic [1:0]  drw;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] din;
        int          done;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        int          rerr;
    } vec_t;

    typedef struct {
        int          done;
        logic [31:0] i;
        logic [31:0] d;
        int          rerr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic i_e, input logic d_e, input logic [1:0] rw,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input int dn,
                                input logic [31:0] ei, input logic [31:0] ed,
                                input int re);
        vec_t v;
        v.ie = i_e; v.de = d_e; v.drw = rw; v.iaddr = ia; v.daddr = da; v.din = wd;
        v.done = dn; v.exp_i = ei; v.exp_d = ed; v.rerr = re;
        return v;
    endfunction

    task automatic do_req(input string name, input vec_t v);
        exp_t        e;
        int          cyc;
        int          rc;
        bit          seen;
        @(posedge clk);
        #1;
        ie = v.ie; de = v.de; drw = v.drw;
        iaddr = v.iaddr; daddr = v.daddr; din = v.din;
        e.done = v.done; e.i = v.exp_i; e.d = v.exp_d; e.rerr = v.rerr;
        sb.push_back(e);
        cyc = 0; rc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (rerr_m) rc++;
            if (!nrdy_m) seen = 1'b1;
            else cyc++;
        end
        e = sb.pop_front();
        if (!seen) cyc = -1;
        chk({name, "/done_cycle"}, cyc, e.done);
        chk({name, "/iout"}, iout_m, e.i);
        chk({name, "/dout"}, dout_m, e.d);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        chk({name, "/range_err_pulses"}, rc, e.rerr);
`endif
        @(posedge clk);
        #1;
        ie = 1'b0; de = 1'b0;
        @(negedge clk);
        chk({name, "/iout_hold"}, iout_m, e.i);
        chk({name, "/dout_hold"}, dout_m, e.d);
    endtask

    vec_t vecs[12];

    initial begin
        rst = 1'b1; ie = 1'b0; de = 1'b0; sel = 1'b0; drw = 2'b00;
        iaddr = 32'd0; daddr = 32'd0; din = 32'd0;

        vecs[0]  = mk(0, 1, 2'b01, 32'h0,  32'h10,   32'hDEADBEEF, 4, 32'h0,        32'h0,        0);
        vecs[1]  = mk(0, 1, 2'b10, 32'h0,  32'h10,   32'h0,        4, 32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 1, 2'b01, 32'h10, 32'h10,   32'h12345678, 5, 32'h12345678, 32'hDEADBEEF, 0);
        vecs[3]  = mk(0, 1, 2'b10, 32'h0,  32'h13,   32'h0,        4, 32'h12345678, 32'h12345678, 0);
        vecs[4]  = mk(0, 1, 2'b01, 32'h0,  32'h20,   32'hAAAA5555, 4, 32'h12345678, 32'h12345678, 0);
        vecs[5]  = mk(1, 0, 2'b00, 32'h20, 32'h0,    32'h0,        4, 32'hAAAA5555, 32'h12345678, 0);
        vecs[6]  = mk(1, 1, 2'b11, 32'h10, 32'h20,   32'h0,        4, 32'h12345678, 32'h12345678, 0);
        vecs[7]  = mk(1, 1, 2'b10, 32'h10, 32'h20,   32'h0,        5, 32'h12345678, 32'hAAAA5555, 0);
        vecs[8]  = mk(0, 1, 2'b01, 32'h0,  32'h3FFC, 32'h0BADF00D, 4, 32'h12345678, 32'hAAAA5555, 0);
        vecs[9]  = mk(1, 1, 2'b10, 32'h3FFC, 32'h3FFC, 32'h0,      5, 32'h0BADF00D, 32'h0BADF00D, 0);
        vecs[10] = mk(0, 1, 2'b01, 32'h0,  32'h0,    32'h5A5A0001, 4, 32'h0BADF00D, 32'h0BADF00D, 0);
        vecs[11] = mk(0, 1, 2'b10, 32'h0,  32'h0,    32'h0,        4, 32'h0BADF00D, 32'h5A5A0001, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle/nrdy", nrdy_m, 1'b0);
            chk("idle/iout", iout_m, 32'h0);
            chk("idle/dout", dout_m, 32'h0);
        end

        // de with an invalid op code and no ie is not a request.
        @(posedge clk);
        #1 de = 1'b1; drw = 2'b00; daddr = 32'h10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("noop/nrdy", nrdy_m, 1'b0);
        end
        @(posedge clk);
        #1 de = 1'b0;

        for (int k = 0; k < 12; k++) begin
            do_req($sformatf("vec%0d", k), vecs[k]);
        end

        // Reset during WAIT of a write to 0x20 drops the write.
        @(posedge clk);
        #1 de = 1'b1; drw = 2'b01; daddr = 32'h20; din = 32'h11111111;
        @(negedge clk);
        chk("rstwait/nrdy_c0", nrdy_m, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstwait/nrdy_c1", nrdy_m, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0; de = 1'b0;
        @(negedge clk);
        chk("rstwait/nrdy_after", nrdy_m, 1'b0);
        chk("rstwait/dout_after", dout_m, 32'h0);
        chk("rstwait/iout_after", iout_m, 32'h0);
        do_req("rstwait_readback", mk(0, 1, 2'b10, 32'h0, 32'h20, 32'h0, 4, 32'h0, 32'hAAAA5555, 0));

        // Address with bit 31 set: zero and a range error, or wrap to word 0.
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        do_req("range_rd", mk(0, 1, 2'b10, 32'h0, 32'h80000000, 32'h0, 4, 32'h0, 32'h0, 1));
`else
        do_req("wrap_rd", mk(0, 1, 2'b10, 32'h0, 32'h80000000, 32'h0, 4, 32'h0, 32'h5A5A0001, 0));
`endif

        // Zero-latency instance.
        sel = 1'b1;
        do_req("lat0_wr", mk(0, 1, 2'b01, 32'h0, 32'h10, 32'h00000077, 2, 32'h0, 32'h0, 0));
        do_req("lat0_ird", mk(1, 0, 2'b00, 32'h10, 32'h0, 32'h0, 2, 32'h00000077, 32'h0, 0));
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
